// File: rtl/izigzag_8x8_buffer.sv
// Inverse-zigzag reorder buffer: coefficients arrive in JPEG zigzag order and
// leave in raster (row-major) order through a ping-pong pair of 64-entry banks.
module izigzag_8x8_buffer #(
  parameter int bits = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [bits-1:0] O,
  output logic            O_valid,
  input  logic            O_ready,
  output logic            O_first,
  output logic            O_last
);

  // Zigzag scan position -> raster position (8*row + col).
  function automatic logic [5:0] zz(input logic [5:0] idx);
    case (idx)
      6'd0:  zz = 6'd0;   6'd1:  zz = 6'd1;   6'd2:  zz = 6'd8;   6'd3:  zz = 6'd16;
      6'd4:  zz = 6'd9;   6'd5:  zz = 6'd2;   6'd6:  zz = 6'd3;   6'd7:  zz = 6'd10;
      6'd8:  zz = 6'd17;  6'd9:  zz = 6'd24;  6'd10: zz = 6'd32;  6'd11: zz = 6'd25;
      6'd12: zz = 6'd18;  6'd13: zz = 6'd11;  6'd14: zz = 6'd4;   6'd15: zz = 6'd5;
      6'd16: zz = 6'd12;  6'd17: zz = 6'd19;  6'd18: zz = 6'd26;  6'd19: zz = 6'd33;
      6'd20: zz = 6'd40;  6'd21: zz = 6'd48;  6'd22: zz = 6'd41;  6'd23: zz = 6'd34;
      6'd24: zz = 6'd27;  6'd25: zz = 6'd20;  6'd26: zz = 6'd13;  6'd27: zz = 6'd6;
      6'd28: zz = 6'd7;   6'd29: zz = 6'd14;  6'd30: zz = 6'd21;  6'd31: zz = 6'd28;
      6'd32: zz = 6'd35;  6'd33: zz = 6'd42;  6'd34: zz = 6'd49;  6'd35: zz = 6'd56;
      6'd36: zz = 6'd57;  6'd37: zz = 6'd50;  6'd38: zz = 6'd43;  6'd39: zz = 6'd36;
      6'd40: zz = 6'd29;  6'd41: zz = 6'd22;  6'd42: zz = 6'd15;  6'd43: zz = 6'd23;
      6'd44: zz = 6'd30;  6'd45: zz = 6'd37;  6'd46: zz = 6'd44;  6'd47: zz = 6'd51;
      6'd48: zz = 6'd58;  6'd49: zz = 6'd59;  6'd50: zz = 6'd52;  6'd51: zz = 6'd45;
      6'd52: zz = 6'd38;  6'd53: zz = 6'd31;  6'd54: zz = 6'd39;  6'd55: zz = 6'd46;
      6'd56: zz = 6'd53;  6'd57: zz = 6'd60;  6'd58: zz = 6'd61;  6'd59: zz = 6'd54;
      6'd60: zz = 6'd47;  6'd61: zz = 6'd55;  6'd62: zz = 6'd62;  6'd63: zz = 6'd63;
      default: zz = 6'd63;
    endcase
  endfunction

  logic [bits-1:0] mem_q [0:127];

  logic [1:0]      full_q, full_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [5:0]      widx_q, widx_d;
  logic [5:0]      ridx_q, ridx_d;
  logic [bits-1:0] o_q, o_d;
  logic            o_valid_q, o_valid_d;
  logic            o_first_q, o_first_d;
  logic            o_last_q, o_last_d;

  logic            accept_s;
  logic            load_s;
  logic [6:0]      waddr_s;
  logic [6:0]      raddr_s;

  assign accept_s = in_valid && !full_q[wbank_q];
  assign load_s   = full_q[rbank_q] && (!o_valid_q || O_ready);
  assign waddr_s  = {wbank_q, zz(widx_q)};
  assign raddr_s  = {rbank_q, ridx_q};

  // Next-state for bank bookkeeping and the output register.
  always_comb begin
    full_d    = full_q;
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    widx_d    = widx_q;
    ridx_d    = ridx_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    o_first_d = o_first_q;
    o_last_d  = o_last_q;

    if (accept_s) begin
      widx_d = widx_q + 6'd1;
      if (widx_q == 6'd63) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end else begin
        wbank_d = wbank_q;
      end
    end else begin
      widx_d = widx_q;
    end

    // Banks under write and read are always distinct, so both flag updates land.
    if (load_s) begin
      o_d       = mem_q[raddr_s];
      o_valid_d = 1'b1;
      o_first_d = (ridx_q == 6'd0);
      o_last_d  = (ridx_q == 6'd63);
      ridx_d    = ridx_q + 6'd1;
      if (ridx_q == 6'd63) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end else begin
        rbank_d = rbank_q;
      end
    end else if (o_valid_q && O_ready) begin
      o_valid_d = 1'b0;
      o_first_d = 1'b0;
      o_last_d  = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= 2'b00;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      widx_q    <= 6'd0;
      ridx_q    <= 6'd0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      o_first_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      full_q    <= full_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      widx_q    <= widx_d;
      ridx_q    <= ridx_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      o_first_q <= o_first_d;
      o_last_q  <= o_last_d;
    end
  end

  // Bank storage; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[waddr_s] <= in;
    end
  end

  assign in_ready = !full_q[wbank_q];
  assign O        = o_q;
  assign O_valid  = o_valid_q;
  assign O_first  = o_first_q;
  assign O_last   = o_last_q;

endmodule

// File: tb/tb_izigzag_8x8_buffer.sv
// Randomized bench for izigzag_8x8_buffer against a queue-of-blocks reference
// model whose zigzag order is derived by walking anti-diagonals.
module tb_izigzag_8x8_buffer;

  localparam int W = 32;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] in_d;
  logic         in_valid, in_ready;
  logic [W-1:0] o;
  logic         o_valid, o_ready, o_first, o_last;

  logic         rst8;
  logic [7:0]   in8;
  logic         in_valid8, in_ready8;
  logic [7:0]   o8;
  logic         o_valid8, o_ready8, o_first8, o_last8;

  izigzag_8x8_buffer #(.bits(W)) dut (
    .clk(clk), .rst(rst), .in(in_d), .in_valid(in_valid), .in_ready(in_ready),
    .O(o), .O_valid(o_valid), .O_ready(o_ready), .O_first(o_first), .O_last(o_last)
  );

  izigzag_8x8_buffer #(.bits(8)) dut8 (
    .clk(clk), .rst(rst8), .in(in8), .in_valid(in_valid8), .in_ready(in_ready8),
    .O(o8), .O_valid(o_valid8), .O_ready(o_ready8), .O_first(o_first8), .O_last(o_last8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef logic [W-1:0] blk_t [64];
  int           zz_tab [64];
  int           zz_inv [64];
  blk_t         blocks [$];
  blk_t         partial;
  int           cnt_in, out_pos, blocks_in;
  logic         exp_valid, exp_first, exp_last;
  logic [W-1:0] exp_o;
  logic [W-1:0] out_log [$];

  task automatic build_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int row = hi; row >= lo; row--) begin
          zz_tab[k] = 8 * row + (s - row);
          k++;
        end
      end else begin
        for (int row = lo; row <= hi; row++) begin
          zz_tab[k] = 8 * row + (s - row);
          k++;
        end
      end
    end
    for (int i = 0; i < 64; i++) zz_inv[zz_tab[i]] = i;
  endtask

  task automatic model_reset();
    blocks.delete();
    cnt_in    = 0;
    out_pos   = 0;
    exp_valid = 1'b0;
    exp_first = 1'b0;
    exp_last  = 1'b0;
    exp_o     = '0;
  endtask

  // One clock: drive, advance model from pre-edge state, compare after the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    bit   acc, ld;
    blk_t nb;
    in_valid = v;
    in_d     = d;
    o_ready  = r;
    acc = v && (blocks.size() < 2);
    ld  = (blocks.size() > 0) && (!exp_valid || r);
    @(posedge clk);
    #1;
    if (ld) begin
      exp_o     = blocks[0][out_pos];
      exp_valid = 1'b1;
      exp_first = (out_pos == 0);
      exp_last  = (out_pos == 63);
      out_pos++;
      if (out_pos == 64) begin
        out_pos = 0;
        void'(blocks.pop_front());
      end
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
      exp_first = 1'b0;
      exp_last  = 1'b0;
    end
    if (acc) begin
      partial[cnt_in] = d;
      cnt_in++;
      if (cnt_in == 64) begin
        for (int k = 0; k < 64; k++) nb[zz_tab[k]] = partial[k];
        blocks.push_back(nb);
        cnt_in = 0;
        blocks_in++;
      end
    end
    check_val("in_ready", in_ready, blocks.size() < 2);
    check_val("O_valid", o_valid, exp_valid);
    check_val("O", o, exp_o);
    check_val("O_first", o_first, exp_first);
    check_val("O_last", o_last, exp_last);
    if (o_valid) out_log.push_back(o);
  endtask

  initial begin
    int exp8 [8] = '{0, 1, 5, 6, 14, 15, 27, 28};
    int cyc;
    int start_blocks;
    logic [7:0] got8 [$];

    build_zigzag();
    blocks_in = 0;
    rst = 1'b0; in_valid = 1'b0; in_d = '0; o_ready = 1'b0;
    rst8 = 1'b0; in_valid8 = 1'b0; in8 = 8'h00; o_ready8 = 1'b0;
    model_reset();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check_val("rst_O", o, 0);
    check_val("rst_O_valid", o_valid, 0);
    check_val("rst_O_first", o_first, 0);
    check_val("rst_O_last", o_last, 0);
    check_val("rst_in_ready", in_ready, 1);
    rst = 1'b1;

    // Single block, in = k
    out_log.delete();
    for (int k = 0; k < 64; k++) step(1'b1, W'(k), 1'b1);
    for (int k = 0; k < 70; k++) step(1'b0, '0, 1'b1);
    check_val("single_count", out_log.size(), 64);
    for (int i = 0; i < 8; i++)
      check_val("single_seq", (out_log.size() > i) ? out_log[i] : 'x, exp8[i]);
    check_val("single_last", (out_log.size() == 64) ? out_log[63] : 'x, 63);

    // Three blocks back-to-back
    for (int k = 0; k < 192; k++) step(1'b1, $urandom, 1'b1);
    for (int k = 0; k < 70; k++) step(1'b0, '0, 1'b1);

    // Backpressure while two blocks fill
    for (int k = 0; k < 130; k++) step(1'b1, W'(k), 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0);
    check_val("bp_in_ready", in_ready, 0);
    check_val("bp_hold_O", o, 0);
    check_val("bp_hold_first", o_first, 1);
    for (int k = 0; k < 140; k++) step(1'b0, '0, 1'b1);

    // Random handshakes over 20 blocks
    start_blocks = blocks_in;
    cyc = 0;
    while ((blocks_in < start_blocks + 20 || blocks.size() > 0 || exp_valid) && cyc < 20000) begin
      step((blocks_in < start_blocks + 20) ? 1'($urandom_range(0, 1)) : 1'b0,
           $urandom, 1'($urandom_range(0, 1)));
      cyc++;
    end
    check_val("rand_done", cyc < 20000, 1);

    // Reset mid-operation
    for (int k = 0; k < 64; k++) step(1'b1, $urandom, 1'b0);
    for (int k = 0; k < 30; k++) step(1'b1, $urandom, 1'b1);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_val("mid_rst_O_valid", o_valid, 0);
    check_val("mid_rst_O", o, 0);
    check_val("mid_rst_in_ready", in_ready, 1);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    out_log.delete();
    for (int k = 0; k < 64; k++) step(1'b1, $urandom, 1'b1);
    for (int k = 0; k < 70; k++) step(1'b0, '0, 1'b1);
    check_val("post_rst_count", out_log.size(), 64);

    // 8-bit instance: all-ones at zigzag index 5 lands on raster 2
    rst8 = 1'b1;
    o_ready8 = 1'b1;
    for (int k = 0; k < 64; k++) begin
      in8 = (k == 5) ? 8'hFF : 8'(k);
      in_valid8 = 1'b1;
      @(posedge clk); #1;
      if (o_valid8) got8.push_back(o8);
    end
    in_valid8 = 1'b0;
    cyc = 0;
    while (got8.size() < 64 && cyc < 200) begin
      @(posedge clk); #1;
      if (o_valid8) got8.push_back(o8);
      cyc++;
    end
    check_val("w8_count", got8.size(), 64);
    for (int p = 0; p < 64; p++)
      check_val("w8_data", (got8.size() > p) ? got8[p] : 8'hxx,
                (p == 2) ? 8'hFF : 8'(zz_inv[p]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/izigzag_8x8_buffer.md
IZIGZAG_8X8_BUFFER -- requirements
Module: izigzag_8x8_buffer

Interface
REQ-001 The block SHALL have parameter `bits`, default 32, giving the coefficient/sample width.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port `in`, input, `bits`: coefficient arriving in JPEG zigzag order.
REQ-005 The block SHALL have port `in_valid`, input, 1 bit: `in` holds a valid coefficient.
REQ-006 The block SHALL have port `in_ready`, output, 1 bit: the block can accept `in` this cycle.
REQ-007 The block SHALL have port `O`, output, `bits`: registered sample, emitted in row-major order.
REQ-008 The block SHALL have port `O_valid`, output, 1 bit: `O` is valid.
REQ-009 The block SHALL have port `O_ready`, input, 1 bit: the downstream stage takes `O` this cycle.
REQ-010 The block SHALL have port `O_first`, output, 1 bit: `O` is element (row 0, col 0) of a block.
REQ-011 The block SHALL have port `O_last`, output, 1 bit: `O` is element (row 7, col 7) of a block.

Function
REQ-012 Storage SHALL be two 64-entry banks of `bits` width (ping-pong), each with a full flag.
REQ-013 Write side: write bank pointer `wbank` and a 6-bit zigzag index `widx`.
  - `in_ready` = !full[wbank].
  - Accept when in_valid && in_ready.
REQ-014 On accept, the block SHALL write `in` to mem[wbank][ZZ(widx)] and increment `widx`.
  - ZZ is the standard JPEG zigzag-to-raster table (raster = 8*row + col).
  - ZZ(0..9) = 0,1,8,16,9,2,3,10,17,24; ZZ(62)=62; ZZ(63)=63.
REQ-015 On the accept with widx==63:
  - set full[wbank];
  - wrap widx to 0;
  - toggle wbank.
REQ-016 Read side: read bank pointer `rbank` and a 6-bit raster index `ridx`.
  - Load the output register when full[rbank] && (!O_valid || O_ready).
  - The load sets O = mem[rbank][ridx] and O_valid = 1.
  - O_first = (ridx==0); O_last = (ridx==63).
  - ridx increments on each load.
REQ-017 On the load with ridx==63:
  - clear full[rbank];
  - wrap ridx to 0;
  - toggle rbank.
  - The freed bank's in_ready SHALL be visible the following cycle.
REQ-018 When O_valid && O_ready and no new load occurs, O_valid, O_first and O_last SHALL clear; O holds its last value.
REQ-019 While O_valid && !O_ready, O, O_first and O_last SHALL stay stable.
REQ-020 Latency: if the 64th coefficient is accepted at edge N, then (0,0) SHALL appear with O_valid=1, O_first=1 after edge N+1 (the bank was empty and the output register was free).
REQ-021 With O_ready held high, one sample per cycle SHALL be output; a block drains in 64 cycles with no bubbles.
REQ-022 Throughput: with both sides continuously active, the block SHALL sustain one coefficient in and one sample out per cycle.
REQ-023 Simultaneous events:
  - The write side may set full on one bank while the read side clears full on the other in the same cycle; both SHALL take effect.
  - Writing bank A while reading bank B SHALL never corrupt B.
REQ-024 When both banks are full, in_ready SHALL be 0 and `in` SHALL be ignored regardless of in_valid.
REQ-025 No arithmetic on data: values pass bit-exact, with no sign extension or truncation.

Reset
REQ-026 When rst=0, the block SHALL immediately (asynchronously) set:
  - full[0] = full[1] = 0; wbank = rbank = 0; widx = ridx = 0;
  - O = 0; O_valid = O_first = O_last = 0.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 A reset mid-block SHALL discard the partial input block and any undrained output block.
REQ-029 After rst returns to 1, in_ready SHALL be 1 from the first rising edge.

Verification
REQ-030 Single block: feed in = k (k=0..63, zigzag order) with O_ready=1.
  - Output sequence = ZZ⁻¹ values: 0,1,5,6,14,15,27,28, 2,4,7,13,...; last = 63.
  - O_first only on the first sample, O_last only on the 64th.
  - First O_valid occurs 1 cycle after the 64th accept.
REQ-031 Back-to-back blocks: stream 3 blocks continuously with O_ready=1.
  - in_ready stays 1 throughout.
  - The output is continuous after the first block, and each block matches its expected raster data.
REQ-032 Backpressure: O_ready=0 while 2 blocks are filled.
  - in_ready drops to 0 after the 128th accept.
  - O holds (0,0) of block 0 stable.
  - Releasing O_ready drains both blocks in order, and in_ready returns to 1 after the 64th output.
REQ-033 Random in_valid/O_ready (50% each) over 20 blocks: the scoreboard sees no loss, duplication or reordering of data.
REQ-034 Reset mid-operation: assert rst=0 after 30 coefficients of block 1 while block 0 is half drained.
  - O_valid falls to 0 and O to 0 immediately.
  - After release, a fresh block outputs correctly starting with O_first=1.
REQ-035 Width: with bits=8, input 8'hFF at zigzag index 5 appears as 8'hFF at raster position 2 (row 0, col 2).
